// File: rtl/w5300_tx_packer_pkg.sv
// Shared W5300 definitions: TX buffer header layout and packer FSM states.
package w5300_tx_packer_pkg;

  localparam int unsigned TX_HDR_WORDS = 2;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned BYTE_CNT_W   = 32;
  localparam int unsigned DROP_CNT_W   = 16;

  typedef enum logic [2:0] {
    FILL,
    DROP,
    HDR_HI,
    HDR_LO,
    REQ
  } tx_packer_state_t;

  // Wire bytes carried by one beat: a final odd beat carries only its high byte.
  function automatic logic [1:0] beat_bytes(input logic odd_last);
    return odd_last ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/w5300_tx_packer.sv
// Packs a 16-bit payload stream into the W5300 TX buffer, prefixes the 32-bit
// byte length in words 0-1, then requests transmission until tx_done.
// Packets larger than the buffer are drained and counted as dropped.
module w5300_tx_packer
  import w5300_tx_packer_pkg::*;
#(
  parameter int unsigned ETH_TX_BUFFER_WIDTH = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_W-1:0]              s_data,
  input  logic                           s_last,
  input  logic                           s_last_odd,
  output logic                           buf_wr_en,
  output logic [ETH_TX_BUFFER_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_W-1:0]              buf_wr_data,
  output logic                           eth_tx_req,
  input  logic                           tx_done,
  output logic                           pkt_dropped,
  output logic [DROP_CNT_W-1:0]          drop_count
);

  localparam int unsigned AW = ETH_TX_BUFFER_WIDTH;
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_START = PW'(TX_HDR_WORDS);
  localparam logic [PW-1:0] PTR_FULL  = PW'(1) << AW;

  tx_packer_state_t      state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  eth_tx_req_q, eth_tx_req_d;
  logic                  pkt_dropped_q, pkt_dropped_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic odd_last;
  assign odd_last = s_last & s_last_odd;

  // Next-state, pointer/counter update and same-cycle buffer write strobes.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    pkt_dropped_d = 1'b0;
    drop_count_d  = drop_count_q;
    s_ready       = 1'b0;
    buf_wr_en     = 1'b0;
    buf_wr_addr   = '0;
    buf_wr_data   = '0;

    unique case (state_q)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (wr_ptr_q != PTR_FULL) begin
            buf_wr_en   = 1'b1;
            buf_wr_addr = wr_ptr_q[AW-1:0];
            buf_wr_data = odd_last ? {s_data[15:8], 8'h00} : s_data;
            wr_ptr_d    = wr_ptr_q + PW'(1);
            byte_cnt_d  = byte_cnt_q + BYTE_CNT_W'(beat_bytes(odd_last));
            if (s_last) begin
              state_d = HDR_HI;
            end
          end else if (s_last) begin
            // Overflowing beat is also the last: drop immediately.
            pkt_dropped_d = 1'b1;
            drop_count_d  = drop_count_q + DROP_CNT_W'(1);
            wr_ptr_d      = PTR_START;
            byte_cnt_d    = '0;
          end else begin
            state_d = DROP;
          end
        end
      end

      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          pkt_dropped_d = 1'b1;
          drop_count_d  = drop_count_q + DROP_CNT_W'(1);
          wr_ptr_d      = PTR_START;
          byte_cnt_d    = '0;
          state_d       = FILL;
        end
      end

      HDR_HI: begin
        buf_wr_en   = 1'b1;
        buf_wr_addr = AW'(0);
        buf_wr_data = byte_cnt_q[31:16];
        state_d     = HDR_LO;
      end

      HDR_LO: begin
        buf_wr_en   = 1'b1;
        buf_wr_addr = AW'(1);
        buf_wr_data = byte_cnt_q[15:0];
        state_d     = REQ;
      end

      REQ: begin
        if (tx_done) begin
          wr_ptr_d   = PTR_START;
          byte_cnt_d = '0;
          state_d    = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // Nothing is accepted or written while reset is asserted.
    if (rst) begin
      s_ready   = 1'b0;
      buf_wr_en = 1'b0;
    end
  end

  assign eth_tx_req_d = (state_d == REQ);

  // State, pointer, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      wr_ptr_q      <= PTR_START;
      byte_cnt_q    <= '0;
      eth_tx_req_q  <= 1'b0;
      pkt_dropped_q <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      eth_tx_req_q  <= eth_tx_req_d;
      pkt_dropped_q <= pkt_dropped_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign eth_tx_req  = eth_tx_req_q;
  assign pkt_dropped = pkt_dropped_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_w5300_tx_packer.sv
// Drives a 9-bit and a 4-bit buffer instance with the same packet stream and
// checks buffer contents, length header, request timing and drop handling.
module tb_w5300_tx_packer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        s_last_odd;
  logic        tx_done;

  logic        s_ready9, wen9, req9, pd9;
  logic [8:0]  addr9;
  logic [15:0] wdata9, dc9;
  logic        s_ready4, wen4, req4, pd4;
  logic [3:0]  addr4;
  logic [15:0] wdata4, dc4;

  w5300_tx_packer #(.ETH_TX_BUFFER_WIDTH(9)) dut9 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready9), .s_data(s_data),
    .s_last(s_last), .s_last_odd(s_last_odd), .buf_wr_en(wen9), .buf_wr_addr(addr9),
    .buf_wr_data(wdata9), .eth_tx_req(req9), .tx_done(tx_done),
    .pkt_dropped(pd9), .drop_count(dc9)
  );

  w5300_tx_packer #(.ETH_TX_BUFFER_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
    .s_last(s_last), .s_last_odd(s_last_odd), .buf_wr_en(wen4), .buf_wr_addr(addr4),
    .buf_wr_data(wdata4), .eth_tx_req(req4), .tx_done(tx_done),
    .pkt_dropped(pd4), .drop_count(dc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer image and event log built from the write port, sampled mid-cycle.
  logic [15:0] mem9 [0:511];
  logic [15:0] mem4 [0:15];
  int wcnt9 = 0, wcnt4 = 0, hdr9 = 0, hdr4 = 0;
  int rise9 = -1, rise4 = -1, drops9 = 0, drops4 = 0;
  logic req9_prev = 1'b0, req4_prev = 1'b0;

  always @(negedge clk) begin
    if (wen9) begin
      mem9[addr9] <= wdata9;
      wcnt9 <= wcnt9 + 1;
      if (addr9 < 9'd2) hdr9 <= hdr9 + 1;
    end
    if (wen4) begin
      mem4[addr4] <= wdata4;
      wcnt4 <= wcnt4 + 1;
      if (addr4 < 4'd2) hdr4 <= hdr4 + 1;
    end
    if (req9 && !req9_prev) rise9 <= cyc;
    if (req4 && !req4_prev) rise4 <= cyc;
    req9_prev <= req9;
    req4_prev <= req4;
    if (pd9) drops9 <= drops9 + 1;
    if (pd4) drops4 <= drops4 + 1;
  end

  typedef struct {
    int          beats;
    bit          odd;
    bit          gaps;
    logic [15:0] first;
    logic [31:0] len;
    bit          drop4;
    bit          hold;
  } case_t;

  int checks = 0;
  int errors = 0;
  int exp_dc4 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input case_t c, input int i);
    logic [15:0] w;
    w = c.first + 16'(i) * 16'h0202;
    if (c.odd && i == c.beats - 1) w[7:0] = 8'h00;
    return w;
  endfunction

  task automatic run_case(input case_t c);
    int w9b, w4b, h9b, h4b, d9b, d4b, lc, notrdy, bad9, bad4, n4;
    w9b = wcnt9; w4b = wcnt4; h9b = hdr9; h4b = hdr4; d9b = drops9; d4b = drops4;
    lc = 0; notrdy = 0; bad9 = 0; bad4 = 0;
    for (int i = 0; i < c.beats; i++) begin
      if (c.gaps) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int g = 0; g < n; g++) begin
          s_valid = 1'b0;
          tx_done = 1'($urandom_range(0, 1));
          s_data  = 16'($urandom);
          step();
          if (!(s_ready9 && s_ready4) || req9 || req4) notrdy++;
        end
        tx_done = 1'b0;
      end
      s_valid    = 1'b1;
      s_data     = c.first + 16'(i) * 16'h0202;
      s_last     = (i == c.beats - 1);
      s_last_odd = c.odd & s_last;
      if (!(s_ready9 && s_ready4)) notrdy++;
      lc = cyc;
      step();
    end
    s_valid = 1'b0; s_last = 1'b0; s_last_odd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (req9 && (c.drop4 || req4)) break;
      step();
    end
    @(negedge clk);
    #1;

    chk("stall_or_req_during_fill", 32'(notrdy), 32'd0);
    chk("req9", 32'(req9), 32'd1);
    chk("req9_latency", 32'(rise9 - lc), 32'd3);
    chk("hdr9_writes", 32'(hdr9 - h9b), 32'd2);
    chk("word0_9", 32'(mem9[0]), 32'(c.len[31:16]));
    chk("word1_9", 32'(mem9[1]), 32'(c.len[15:0]));
    chk("writes9", 32'(wcnt9 - w9b), 32'(c.beats + 2));
    chk("ready9_in_req", 32'(s_ready9), 32'd0);
    chk("drop9", 32'(drops9 - d9b), 32'd0);
    for (int i = 0; i < c.beats; i++) if (mem9[2 + i] !== exp_word(c, i)) bad9++;
    chk("payload9", 32'(bad9), 32'd0);

    n4 = c.drop4 ? 14 : c.beats;
    for (int i = 0; i < n4; i++) if (mem4[2 + i] !== exp_word(c, i)) bad4++;
    chk("payload4", 32'(bad4), 32'd0);
    if (c.drop4) begin
      exp_dc4++;
      chk("writes4_drop", 32'(wcnt4 - w4b), 32'd14);
      chk("hdr4_drop", 32'(hdr4 - h4b), 32'd0);
      chk("drop_pulse4", 32'(drops4 - d4b), 32'd1);
      chk("req4_drop", 32'(req4), 32'd0);
      chk("ready4_drop", 32'(s_ready4), 32'd1);
    end else begin
      chk("req4", 32'(req4), 32'd1);
      chk("req4_latency", 32'(rise4 - lc), 32'd3);
      chk("word0_4", 32'(mem4[0]), 32'(c.len[31:16]));
      chk("word1_4", 32'(mem4[1]), 32'(c.len[15:0]));
      chk("writes4", 32'(wcnt4 - w4b), 32'(c.beats + 2));
      chk("drop_pulse4", 32'(drops4 - d4b), 32'd0);
    end
    chk("drop_count4", 32'(dc4), 32'(exp_dc4));

    if (!c.hold) begin
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("req9_release", 32'(req9), 32'd0);
      chk("req4_release", 32'(req4), 32'd0);
      chk("ready9_release", 32'(s_ready9), 32'd1);
      chk("ready4_release", 32'(s_ready4), 32'd1);
    end
  endtask

  case_t cases [7];

  initial begin
    cases[0] = '{beats: 8,  odd: 1'b1, gaps: 1'b0, first: 16'h0102, len: 32'd15, drop4: 1'b0, hold: 1'b0};
    cases[1] = '{beats: 14, odd: 1'b0, gaps: 1'b0, first: 16'h0102, len: 32'h1C, drop4: 1'b0, hold: 1'b0};
    cases[2] = '{beats: 16, odd: 1'b0, gaps: 1'b0, first: 16'h0102, len: 32'd32, drop4: 1'b1, hold: 1'b0};
    cases[3] = '{beats: 1,  odd: 1'b1, gaps: 1'b0, first: 16'hAB55, len: 32'd1,  drop4: 1'b0, hold: 1'b0};
    cases[4] = '{beats: 8,  odd: 1'b1, gaps: 1'b1, first: 16'h0102, len: 32'd15, drop4: 1'b0, hold: 1'b0};
    cases[5] = '{beats: 3,  odd: 1'b0, gaps: 1'b0, first: 16'h1111, len: 32'd6,  drop4: 1'b0, hold: 1'b1};
    cases[6] = '{beats: 2,  odd: 1'b0, gaps: 1'b0, first: 16'hC0DE, len: 32'd4,  drop4: 1'b0, hold: 1'b0};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_last_odd = 1'b0; tx_done = 1'b0;
    s_valid = 1'b1;
    step();
    step();
    chk("rst_wen9", 32'(wen9), 32'd0);
    chk("rst_wen4", 32'(wen4), 32'd0);
    chk("rst_req9", 32'(req9), 32'd0);
    chk("rst_pd4", 32'(pd4), 32'd0);
    chk("rst_dc4", 32'(dc4), 32'd0);
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_ready9", 32'(s_ready9), 32'd1);
    chk("rst_ready4", 32'(s_ready4), 32'd1);

    for (int t = 0; t < 7; t++) begin
      run_case(cases[t]);
      if (cases[t].hold) begin
        // Reset while the request is pending: the packet is abandoned.
        rst = 1'b1;
        step();
        chk("midreq_rst_wen9", 32'(wen9), 32'd0);
        rst = 1'b0;
        #1;
        chk("midreq_req9", 32'(req9), 32'd0);
        chk("midreq_req4", 32'(req4), 32'd0);
        chk("midreq_ready9", 32'(s_ready9), 32'd1);
        chk("midreq_ready4", 32'(s_ready4), 32'd1);
        chk("midreq_dc4", 32'(dc4), 32'd0);
        exp_dc4 = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w5300_tx_packer.md
Name: w5300_tx_packer

Overview:
Upstream stage of w5300_transmitter. Accepts a 16-bit big-endian payload stream from the application and writes it into the Ethernet TX buffer at word 2 onward. On end of packet it writes the 32-bit byte length into words 0–1, then holds eth_tx_req until the transmitter pulses tx_done. Packets that do not fit the buffer are drained from the stream and dropped.

Parameters:
ETH_TX_BUFFER_WIDTH, 9, TX buffer address width; capacity 2^W words, of which 2 are header.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
s_valid  in  1  payload beat valid
s_ready  out  1  payload beat accepted when s_valid&s_ready
s_data  in  16  payload word; [15:8] is the earlier byte on the wire
s_last  in  1  final beat of packet
s_last_odd  in  1  qualifies s_last; only s_data[15:8] is valid
buf_wr_en  out  1  TX buffer write strobe
buf_wr_addr  out  ETH_TX_BUFFER_WIDTH  TX buffer write address
buf_wr_data  out  16  TX buffer write data
eth_tx_req  out  1  packet ready; to w5300_transmitter
tx_done  in  1  one-cycle pulse from w5300_transmitter
pkt_dropped  out  1  one-cycle pulse when an oversize packet is discarded
drop_count  out  16  count of dropped packets, wraps

Behaviour:
- Reset (synchronous, active-high) forces state FILL, wr_ptr=2, byte_cnt=0, eth_tx_req=0, pkt_dropped=0, drop_count=0. buf_wr_en=0 in the reset cycle. Applies mid-packet and mid-REQ; the partial packet is lost.
- wr_ptr is ETH_TX_BUFFER_WIDTH+1 bits. byte_cnt is 32 bits.
- FILL: s_ready=1. On an accepted beat with wr_ptr<2^W, in the same cycle: buf_wr_en=1, buf_wr_addr=wr_ptr, buf_wr_data=s_data, with the low byte forced to 0x00 if s_last&s_last_odd. wr_ptr+=1. byte_cnt += (s_last&s_last_odd)?1:2.
  - Accepted beat with s_last → HDR_HI.
  - Accepted beat with wr_ptr==2^W (overflow): no write. If s_last, pulse pkt_dropped, drop_count+=1, reset wr_ptr/byte_cnt, stay in FILL. Otherwise → DROP.
- DROP: s_ready=1, no writes. On an accepted s_last beat: pulse pkt_dropped, drop_count+=1, wr_ptr=2, byte_cnt=0, → FILL.
- HDR_HI: s_ready=0; write addr 0 with byte_cnt[31:16]; → HDR_LO.
- HDR_LO: s_ready=0; write addr 1 with byte_cnt[15:0]; → REQ. eth_tx_req is registered and goes high at the next edge.
- REQ: s_ready=0, eth_tx_req=1, no writes. On tx_done: eth_tx_req=0 at the next edge, wr_ptr=2, byte_cnt=0, → FILL.
- Latency: s_last accepted in cycle t → word0 written in t+1, word1 in t+2, eth_tx_req high from t+3.
- tx_done outside REQ: ignored. tx_done in the same cycle as entry into REQ cannot occur; eth_tx_req must be observed first.
- Exactly-full packet (2^W−2 beats, last at addr 2^W−1): accepted normally; not a drop.
- s_valid gaps anywhere: no effect beyond a stall.
- Wire byte length = 2·beats − (s_last_odd?1:0).

Decomposition:
- Shared W5300 package gains TX_HDR_WORDS=2 (payload start address) and the enum tx_packer_state_t {FILL, DROP, HDR_HI, HDR_LO, REQ}.
- No sub-module: a single FSM with pointer and counter is natural.

Test Plan:
- W=9; 8 beats 0x0102..0x0F10, last with s_last_odd → words 2..9 written, word 9 low byte = 0x00; word0=0x0000, word1=0x000F; eth_tx_req rises 3 cycles after the last beat; s_ready=0 until tx_done; req drops 1 cycle after tx_done.
- W=4 (capacity 14 payload words); 14 beats, even → writes to addr 2..15, word1=0x001C, eth_tx_req asserted, no pkt_dropped.
- W=4; 16 beats → 14 writes to addr 2..15, then no write on beat 15; pkt_dropped pulses on beat 16 (s_last); drop_count=1; no header writes; eth_tx_req stays 0; next packet starts at addr 2.
- Single odd beat 0xAB55 with s_last_odd → addr2=0xAB00, word1=0x0001.
- Assert rst for 1 cycle while in REQ → eth_tx_req=0 next cycle, s_ready=1; new 2-beat packet writes addr 2,3 and length 4.
- Random s_valid gaps plus spurious tx_done pulses during FILL → buffer contents and length identical to the gap-free run; no state change from the spurious tx_done.
